// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - framed command parser fed from a UART RX FIFO
// Frame: 0xA5, OPCODE, LEN, LEN payload bytes, CHK (XOR of OPCODE, LEN, payload).
// Ports:
//   clk210_p, reset_n_p              : clock, asynchronous active-low reset
//   fifo_rx_dout_p/_empty_p/_rd_en_p : RX FIFO read side, data valid the cycle after rd_en
//   cmd_valid_p, cmd_ack_p           : decoded command handshake
//   cmd_opcode_p/_len_p/_payload_p   : decoded command fields (payload byte i at [8i+7:8i])
//   frame_err_p, err_count_p         : one-cycle error pulse, saturating error count
// Option: define UART_CMD_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYCLES
// idle cycles; without it a partial frame waits for more bytes forever.
module uart_cmd_parser #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 2100000
) (
  input  logic                 clk210_p,
  input  logic                 reset_n_p,
  input  logic [7:0]           fifo_rx_dout_p,
  input  logic                 fifo_rx_empty_p,
  output logic                 fifo_rx_rd_en_p,
  output logic                 cmd_valid_p,
  input  logic                 cmd_ack_p,
  output logic [7:0]           cmd_opcode_p,
  output logic [4:0]           cmd_len_p,
  output logic [8*MAX_LEN-1:0] cmd_payload_p,
  output logic                 frame_err_p,
  output logic [7:0]           err_count_p
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_OPCODE, S_LEN, S_PAYLOAD, S_CHK, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 rd_en_q, rd_en_d;
  logic                 byte_vld_q;      // read data is on fifo_rx_dout_p this cycle
  logic [7:0]           opcode_q, opcode_d;
  logic [4:0]           len_q, len_d;
  logic [4:0]           idx_q, idx_d;
  logic [7:0]           chk_q, chk_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic                 frame_err_q, frame_err_d;
  logic [7:0]           err_cnt_q;
  logic                 len_bad;
  logic                 tmo_hit;

  assign len_bad = fifo_rx_dout_p > MAX_LEN_B;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_active;

  assign tmo_active = (state_q == S_OPCODE) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign tmo_d      = (byte_vld_q || !tmo_active) ? '0 : tmo_q + 1'b1;
  // Fires on the cycle the count would reach TIMEOUT_CYCLES, so the error
  // pulse starts exactly TIMEOUT_CYCLES edges after the last capture.
  assign tmo_hit    = tmo_active && !byte_vld_q && (tmo_q == TMO_LAST);

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) state_q <= S_SYNC;
    else            state_q <= state_d;
  end

  // Next state, error detection and read scheduling
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE:    state_d = S_SYNC;
      S_SYNC:    if (byte_vld_q && fifo_rx_dout_p == SYNC_BYTE) state_d = S_OPCODE;
      S_OPCODE:  if (byte_vld_q) state_d = S_LEN;
      S_LEN: begin
        if (byte_vld_q) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            state_d     = S_SYNC;
          end else if (fifo_rx_dout_p == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: if (byte_vld_q && (idx_q + 5'd1 == len_q)) state_d = S_CHK;
      S_CHK: begin
        if (byte_vld_q) begin
          if (fifo_rx_dout_p == chk_q) begin
            state_d = S_DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_SYNC;
          end
        end
      end
      S_DONE:    if (cmd_ack_p) state_d = S_SYNC;
      default:   state_d = S_SYNC;
    endcase
    if (tmo_hit) begin
      frame_err_d = 1'b1;
      state_d     = S_SYNC;
    end
    // Looking at state_d keeps a read from landing in the first DONE cycle
    // when the CHK byte is being captured right now.
    rd_en_d = !fifo_rx_empty_p && (state_d != S_DONE) && !rd_en_q;
  end

  // Outputs
  always_comb begin
    cmd_valid_p     = (state_q == S_DONE);
    fifo_rx_rd_en_p = rd_en_q;
    cmd_opcode_p    = opcode_q;
    cmd_len_p       = len_q;
    cmd_payload_p   = payload_q;
    frame_err_p     = frame_err_q;
    err_count_p     = err_cnt_q;
  end

  // Field capture
  always_comb begin
    opcode_d  = opcode_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    payload_d = payload_q;
    if (byte_vld_q) begin
      case (state_q)
        S_OPCODE: begin
          opcode_d = fifo_rx_dout_p;
          chk_d    = fifo_rx_dout_p;
        end
        S_LEN: begin
          if (!len_bad) begin
            len_d = fifo_rx_dout_p[4:0];
            chk_d = chk_q ^ fifo_rx_dout_p;
            idx_d = 5'd0;
          end
        end
        S_PAYLOAD: begin
          for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 5'(i)) payload_d[8*i +: 8] = fifo_rx_dout_p;
          end
          chk_d = chk_q ^ fifo_rx_dout_p;
          idx_d = idx_q + 5'd1;
        end
        default: ;
      endcase
    end
    // An aborted frame must not leave stale bytes behind for a shorter frame.
    if ((state_q == S_DONE && cmd_ack_p) || frame_err_d) payload_d = '0;
  end

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      rd_en_q     <= 1'b0;
      byte_vld_q  <= 1'b0;
      opcode_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      payload_q   <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      byte_vld_q  <= rd_en_q;
      opcode_q    <= opcode_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      payload_q   <= payload_d;
      frame_err_q <= frame_err_d;
      if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic                 clk = 1'b0;
  logic                 reset_n_p;
  logic [7:0]           fifo_rx_dout_p;
  logic                 fifo_rx_empty_p;
  logic                 fifo_rx_rd_en_p;
  logic                 cmd_valid_p;
  logic                 cmd_ack_p;
  logic [7:0]           cmd_opcode_p;
  logic [4:0]           cmd_len_p;
  logic [8*MAX_LEN-1:0] cmd_payload_p;
  logic                 frame_err_p;
  logic [7:0]           err_count_p;

  always #5 clk = ~clk;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk210_p        (clk),
    .reset_n_p       (reset_n_p),
    .fifo_rx_dout_p  (fifo_rx_dout_p),
    .fifo_rx_empty_p (fifo_rx_empty_p),
    .fifo_rx_rd_en_p (fifo_rx_rd_en_p),
    .cmd_valid_p     (cmd_valid_p),
    .cmd_ack_p       (cmd_ack_p),
    .cmd_opcode_p    (cmd_opcode_p),
    .cmd_len_p       (cmd_len_p),
    .cmd_payload_p   (cmd_payload_p),
    .frame_err_p     (frame_err_p),
    .err_count_p     (err_count_p)
  );

  typedef struct {
    bit                   is_err;
    logic [7:0]           op;
    int                   len;
    logic [8*MAX_LEN-1:0] pl;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];

  int tests = 0;
  int fails = 0;
  int exp_errs = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int hold = 2;
  int ack_hold_max = 4;
  bit gap_en = 1'b0;
  bit spur_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push_seq(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic exp_cmd(input logic [7:0] op, input int len, input logic [127:0] pl);
    exp_t e;
    e.is_err = 1'b0; e.op = op; e.len = len; e.pl = pl;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1; e.op = '0; e.len = 0; e.pl = '0;
    exp_q.push_back(e);
  endtask

  // kind: 0 good, 1 corrupted CHK, 2 LEN above MAX_LEN
  task automatic push_frame(input logic [7:0] op, input int len, input int kind);
    exp_t       e;
    logic [7:0] x, b;
    e.is_err = (kind != 0); e.op = op; e.len = len; e.pl = '0;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(op);
    if (kind == 2) begin
      fifo_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      fifo_q.push_back(8'(len));
      x = op ^ 8'(len);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        e.pl[8*i +: 8] = b;
        fifo_q.push_back(b);
        x = x ^ b;
      end
      if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
      fifo_q.push_back(x);
    end
    exp_q.push_back(e);
  endtask

  task automatic push_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      fifo_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !cmd_valid_p && !fifo_rx_rd_en_p)
        done = 1'b1;
    end
    check("drain_in_budget", done, 1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pops on the strobe so data is valid through the following cycle.
  initial begin : fifo_drv
    fifo_rx_dout_p  = 8'h00;
    fifo_rx_empty_p = 1'b1;
    forever begin
      @(negedge clk);
      if (fifo_rx_rd_en_p) begin
        check("rd_when_empty", fifo_q.size() > 0, 1'b1);
        if (fifo_q.size() > 0) fifo_rx_dout_p = fifo_q.pop_front();
        last_rd_cyc = cyc;
      end
      fifo_rx_empty_p = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    end
  end

  initial begin : ack_drv
    cmd_ack_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n_p || cmd_ack_p) begin
        cmd_ack_p = 1'b0;
      end else if (cmd_valid_p) begin
        if (hold == 0) begin
          cmd_ack_p = 1'b1;
          hold = $urandom_range(0, ack_hold_max);
        end else begin
          hold--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        cmd_ack_p = 1'b1;
      end
    end
  end

  // Scoreboard monitor
  exp_t                 mon_e;
  logic [7:0]           snap_op;
  logic [4:0]           snap_len;
  logic [8*MAX_LEN-1:0] snap_pl;
  bit prev_valid = 1'b0, prev_ack = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (!reset_n_p) begin
      prev_valid = 1'b0; prev_ack = 1'b0; prev_err = 1'b0;
    end else begin
      if (frame_err_p) begin
        check("err_pulse_one_cycle", prev_err, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_frame_err", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_err", mon_e.is_err, 1'b1);
          exp_errs = (exp_errs == 255) ? 255 : exp_errs + 1;
          check("err_count", err_count_p, exp_errs);
        end
      end
      if (cmd_valid_p && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_cmd", mon_e.is_err, 1'b0);
          check("cmd_opcode", cmd_opcode_p, mon_e.op);
          check("cmd_len", cmd_len_p, mon_e.len);
          check("cmd_payload", cmd_payload_p, mon_e.pl);
        end
        snap_op = cmd_opcode_p; snap_len = cmd_len_p; snap_pl = cmd_payload_p;
      end
      if (cmd_valid_p) check("no_read_in_done", fifo_rx_rd_en_p, 1'b0);
      if (cmd_valid_p && prev_valid) begin
        check("valid_drop_after_ack", prev_ack, 1'b0);
        check("stable_opcode", cmd_opcode_p, snap_op);
        check("stable_len", cmd_len_p, snap_len);
        check("stable_payload", cmd_payload_p, snap_pl);
      end
      if (!cmd_valid_p && prev_valid) begin
        check("drop_only_on_ack", prev_ack, 1'b1);
        check("payload_cleared", cmd_payload_p, 0);
      end
      prev_valid = cmd_valid_p; prev_ack = cmd_ack_p; prev_err = frame_err_p;
    end
  end

  initial begin : main
    int t_err;
    reset_n_p = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", fifo_rx_rd_en_p, 1'b0);
    check("rst_valid", cmd_valid_p, 1'b0);
    check("rst_opcode", cmd_opcode_p, 0);
    check("rst_len", cmd_len_p, 0);
    check("rst_payload", cmd_payload_p, 0);
    check("rst_frame_err", frame_err_p, 1'b0);
    check("rst_err_count", err_count_p, 0);
    reset_n_p = 1'b1;

    // Directed frames; CHK of 10 02 11 22 is 0x21.
    push_seq(64'hA5_10_02_11_22_21, 6);  exp_cmd(8'h10, 2, 128'h2211);
    push_seq(64'h00_FF_A5_07_00_07, 6);  exp_cmd(8'h07, 0, 128'h0);
    push_seq(64'hA5_10_01_55_00, 5);     exp_err();
    push_frame(8'h3C, 3, 0);
    push_seq(64'hA5_01_11, 3);           exp_err();
    push_frame(8'h01, MAX_LEN, 0);
    wait_drain(5000);

    // Consumer stalls with frames queued behind.
    ack_hold_max = 40; hold = 40;
    push_frame(8'h21, 4, 0); push_frame(8'h22, 0, 0); push_frame(8'h23, 9, 0);
    wait_drain(5000);
    ack_hold_max = 4;

    // Randomised traffic with FIFO gaps and stray acks.
    gap_en = 1'b1; spur_en = 1'b1;
    push_frame(8'($urandom), 0, 0);
    push_frame(8'($urandom), MAX_LEN, 0);
    for (int n = 0; n < 150; n++) begin
      int r;
      push_junk($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      push_frame(8'($urandom), $urandom_range(0, MAX_LEN), (r < 7) ? 0 : (r < 9) ? 1 : 2);
    end
    wait_drain(20000);
    gap_en = 1'b0; spur_en = 1'b0;

`ifdef UART_CMD_TIMEOUT_EN
    push_seq(64'hA5_10, 2); exp_err();
    t_err = 0;
    for (int i = 0; i < 400 && t_err == 0; i++) begin
      @(negedge clk);
      if (frame_err_p) t_err = cyc;
    end
    check("timeout_latency", t_err - last_rd_cyc, TMO + 2);
    wait_drain(2000);
`endif

    // Error counter saturation.
    for (int n = 0; n < 260; n++) push_frame(8'($urandom), 0, 2);
    push_frame(8'h5E, 5, 0);
    wait_drain(20000);
    check("err_count_saturated", err_count_p, 8'hFF);

    // Asynchronous reset in the middle of a frame.
    push_seq(64'hA5_10_02_11, 4);
    for (int i = 0; i < 50 && fifo_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3 reset_n_p = 1'b0;
    #1;
    check("midrst_rd_en", fifo_rx_rd_en_p, 1'b0);
    check("midrst_valid", cmd_valid_p, 1'b0);
    check("midrst_opcode", cmd_opcode_p, 0);
    check("midrst_len", cmd_len_p, 0);
    check("midrst_payload", cmd_payload_p, 0);
    check("midrst_frame_err", frame_err_p, 1'b0);
    check("midrst_err_count", err_count_p, 0);
    exp_errs = 0;
    repeat (2) @(negedge clk);
    reset_n_p = 1'b1;
    push_frame(8'h77, 6, 0);
    push_frame(8'h78, 2, 1);
    wait_drain(5000);
    check("final_err_count", err_count_p, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
